// File: rtl/mem_arb_pkg.sv
// Shared encodings for the byte-serial memory port arbiter.
// Holds the FSM states, grant ids, request field values and the big-endian lane helper.
package mem_arb_pkg;

  localparam int unsigned LANES = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  localparam logic RW_STORE  = 1'b1;
  localparam logic SIZE_WORD = 1'b1;

  // Byte cycle 0 carries the most significant byte of the word.
  function automatic logic [7:0] be_lane(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_byte_seq.sv
// Byte sequencer: lane counter, store lane select and read-word assembly.
// word_o already includes the byte on the bus, so it is complete on the last byte cycle.
module byte_seq
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        advance_i,
  input  logic        shift_i,
  input  logic        size_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  rbyte_i,
  output logic [1:0]  cnt_o,
  output logic        last_o,
  output logic [7:0]  wbyte_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] asm_q, asm_d;

  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (clear_i) begin
      cnt_d = '0;
      asm_d = '0;
    end else begin
      if (advance_i) cnt_d = cnt_q + 2'd1;
      if (shift_i)   asm_d = {asm_q[15:0], rbyte_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign last_o  = (size_i != SIZE_WORD) || (cnt_q == 2'(LANES - 1));
  assign wbyte_o = (size_i == SIZE_WORD) ? be_lane(wdata_i, cnt_q) : wdata_i[7:0];
  assign word_o  = {asm_q, rbyte_i};

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a byte-wide memory between instruction fetch and data access,
// serialising each 32-bit access into big-endian byte cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_rw,
  input  logic              dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              pc_stall,
  output logic              mem_stall
);

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              rw_q, rw_d;
  logic              size_q, size_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic              seq_clear, seq_advance, seq_shift, seq_last;
  logic [1:0]        seq_cnt;
  logic [7:0]        seq_wbyte;
  logic [DATA_W-1:0] seq_word;
  logic              xfer;

  assign xfer = (state_q == XFER);

  byte_seq u_seq (
    .clk       (clk),
    .rst_n     (reset),
    .clear_i   (seq_clear),
    .advance_i (seq_advance),
    .shift_i   (seq_shift),
    .size_i    (size_q),
    .wdata_i   (wdata_q),
    .rbyte_i   (mem_rdata),
    .cnt_o     (seq_cnt),
    .last_o    (seq_last),
    .wbyte_o   (seq_wbyte),
    .word_o    (seq_word)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rw_d         = rw_q;
    size_d       = size_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    seq_clear    = 1'b0;
    seq_advance  = 1'b0;
    seq_shift    = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          grant_d = (dm_req && !(if_req && last_grant_q == GRANT_DM)) ? GRANT_DM : GRANT_IF;
          if (grant_d == GRANT_DM) begin
            rw_d    = dm_rw;
            size_d  = dm_size;
            base_d  = dm_addr;
            wdata_d = dm_wdata;
          end else begin
            rw_d    = ~RW_STORE;
            size_d  = SIZE_WORD;
            base_d  = if_addr;
            wdata_d = '0;
          end
          seq_clear = 1'b1;
          state_d   = XFER;
        end
      end
      XFER: begin
        seq_advance = ~seq_last;
        seq_shift   = (rw_q != RW_STORE);
        if (seq_last) begin
          state_d = DONE;
          // Read data is captured on the final byte edge so it is valid while done is high.
          if (rw_q != RW_STORE) begin
            if (grant_q == GRANT_IF)      if_rdata_d = seq_word;
            else if (size_q == SIZE_WORD) dm_rdata_d = seq_word;
            else                          dm_rdata_d = {{(DATA_W-8){1'b0}}, mem_rdata};
          end
        end
      end
      DONE: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_IF;
      last_grant_q <= GRANT_IF;
      rw_q         <= 1'b0;
      size_q       <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rw_q         <= rw_d;
      size_q       <= size_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = (state_q == DONE) && (grant_q == GRANT_IF);
  assign dm_done   = (state_q == DONE) && (grant_q == GRANT_DM);

  assign mem_en    = xfer;
  assign mem_we    = xfer && (rw_q == RW_STORE);
  assign mem_addr  = !xfer ? '0
                   : (size_q == SIZE_WORD) ? {base_q[ADDR_W-1:2], seq_cnt}
                   : base_q;
  assign mem_wdata = mem_we ? seq_wbyte : '0;

  assign pc_stall  = if_req & ~if_done;
  assign mem_stall = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transfers plus
// contention and mid-transfer reset sequences against a byte-wide memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [7:0]  if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req, dm_rw, dm_size;
  logic [7:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic        dm_done;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        pc_stall, mem_stall;

  logic [7:0]  mem [256];
  logic        pre_we;
  logic [7:0]  pre_addr, pre_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_dm;
    logic        rw;
    logic        size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          nbytes;
    logic [7:0]  first;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    else if (pre_we)      mem[pre_addr] <= pre_data;
  end

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_req    (dm_req),
    .dm_rw     (dm_rw),
    .dm_size   (dm_size),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pc_stall  (pc_stall),
    .mem_stall (mem_stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk); #1;
    pre_we   = 1'b0;
  endtask

  // Issues one request in an IDLE cycle (cycle 0) and checks its whole transfer.
  task automatic run_vec(input vec_t v, input string name);
    int         done_cyc;
    int         nb;
    logic [7:0] first;
    logic       other_done;
    logic       we_bad;
    logic [31:0] rd;
    done_cyc = -1; nb = 0; first = '0; other_done = 1'b0; we_bad = 1'b0; rd = '0;
    if (v.is_dm) begin
      dm_req = 1'b1; dm_rw = v.rw; dm_size = v.size; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    check($sformatf("%s_stall_c0", name), {31'b0, v.is_dm ? mem_stall : pc_stall}, 32'd1);
    for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        if_addr = ~v.addr; dm_addr = ~v.addr; dm_wdata = ~v.wdata;
        dm_rw = ~v.rw; dm_size = ~v.size;
      end
      if (mem_en) begin
        if (nb == 0) first = mem_addr;
        nb++;
        if (mem_we !== v.rw) we_bad = 1'b1;
      end
      if (v.is_dm ? if_done : dm_done) other_done = 1'b1;
      if (v.is_dm ? dm_done : if_done) begin
        done_cyc = c;
        rd = v.is_dm ? dm_rdata : if_rdata;
        check($sformatf("%s_stall_done", name), {31'b0, v.is_dm ? mem_stall : pc_stall}, 32'd0);
        if_req = 1'b0; dm_req = 1'b0;
      end
    end
    if (done_cyc < 0) begin
      if_req = 1'b0; dm_req = 1'b0;
    end
    check($sformatf("%s_done_cycle", name), done_cyc, v.nbytes + 1);
    check($sformatf("%s_byte_cycles", name), nb, v.nbytes);
    check($sformatf("%s_first_addr", name), {24'b0, first}, {24'b0, v.first});
    check($sformatf("%s_rdata", name), rd, v.exp_rdata);
    check($sformatf("%s_we", name), {31'b0, we_bad}, 32'd0);
    check($sformatf("%s_other_done", name), {31'b0, other_done}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int          seen;
    int          cyc[4];
    logic        port[4];
    logic [31:0] rdv[4];
    logic        rst_done;
    vec_t        fresh;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h12, 32'h0,        32'hE3A01005, 4, 8'h10};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h20, 32'hDEADBEEF, 32'h00000000, 4, 8'h20};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h20, 32'h0,        32'hDEADBEEF, 4, 8'h20};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h22, 32'h0,        32'h000000BE, 1, 8'h22};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 8'h21, 32'h12345677, 32'h000000BE, 1, 8'h21};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h23, 32'h0,        32'hDE77BEEF, 4, 8'h20};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 8'h13, 32'h0,        32'h00000005, 1, 8'h13};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 8'h21, 32'h0,        32'hDE77BEEF, 4, 8'h20};

    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_rw = 1'b0; dm_size = 1'b0; dm_addr = '0; dm_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    #2;
    for (int a = 0; a < 256; a++) preload(8'(a), 8'h00);
    preload(8'h10, 8'hE3);
    preload(8'h11, 8'hA0);
    preload(8'h12, 8'h10);
    preload(8'h13, 8'h05);

    check("rst_if_done",   {31'b0, if_done},  32'd0);
    check("rst_dm_done",   {31'b0, dm_done},  32'd0);
    check("rst_if_rdata",  if_rdata,          32'd0);
    check("rst_dm_rdata",  dm_rdata,          32'd0);
    check("rst_mem_en",    {31'b0, mem_en},   32'd0);
    check("rst_mem_we",    {31'b0, mem_we},   32'd0);
    check("rst_mem_addr",  {24'b0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'b0, mem_wdata},32'd0);
    if_req = 1'b1; dm_req = 1'b1; #1;
    check("rst_pc_stall",  {31'b0, pc_stall},  32'd1);
    check("rst_mem_stall", {31'b0, mem_stall}, 32'd1);
    if_req = 1'b0; dm_req = 1'b0; #1;
    check("rst_pc_stall_low", {31'b0, pc_stall}, 32'd0);

    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Both ports requesting continuously: DM first, then strict alternation.
    seen = 0;
    if_req = 1'b1; if_addr = 8'h10;
    dm_req = 1'b1; dm_rw = 1'b0; dm_size = 1'b1; dm_addr = 8'h20; dm_wdata = '0;
    for (int c = 1; c <= 40 && seen < 4; c++) begin
      @(posedge clk); #1;
      if (if_done || dm_done) begin
        cyc[seen]  = c;
        port[seen] = dm_done;
        rdv[seen]  = dm_done ? dm_rdata : if_rdata;
        seen++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    check("arb_done_count", seen, 4);
    for (int k = 0; k < 4 && k < seen; k++) begin
      check($sformatf("arb%0d_cycle", k), cyc[k], 5 + 6 * k);
      check($sformatf("arb%0d_port", k), {31'b0, port[k]}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("arb%0d_rdata", k), rdv[k], (k % 2 == 0) ? 32'hDE77BEEF : 32'hE3A01005);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset lands after byte cycles 0 and 1 of a word store have completed.
    dm_req = 1'b1; dm_rw = 1'b1; dm_size = 1'b1; dm_addr = 8'h40; dm_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_addr_c2", {24'b0, mem_addr}, 32'h41);
    @(posedge clk); #1;
    check("rst_mid_en_before", {31'b0, mem_en}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_en_async", {31'b0, mem_en}, 32'd0);
    check("rst_mid_we_async", {31'b0, mem_we}, 32'd0);
    check("rst_mid_stall",    {31'b0, mem_stall}, 32'd1);
    rst_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (dm_done) rst_done = 1'b1;
    end
    dm_req = 1'b0;
    check("rst_mid_no_done", {31'b0, rst_done}, 32'd0);
    check("rst_mid_mem40", {24'b0, mem[8'h40]}, 32'hCA);
    check("rst_mid_mem41", {24'b0, mem[8'h41]}, 32'hFE);
    check("rst_mid_mem42", {24'b0, mem[8'h42]}, 32'h00);
    check("rst_mid_mem43", {24'b0, mem[8'h43]}, 32'h00);
    check("rst_mid_dm_rdata", dm_rdata, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    fresh = '{1'b1, 1'b0, 1'b1, 8'h40, 32'h0, 32'hCAFE0000, 4, 8'h40};
    run_vec(fresh, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single byte-wide data memory between instruction fetch and the MEM stage of the ARM pipeline. Each 32-bit access becomes a sequence of single-byte memory cycles. The block arbitrates between the fetch port and the data port, assembles read words big-endian, and drives the stall outputs that freeze the PC/IF_ID (fetch side) and the pipeline (data side) until each transfer completes.

## Interface
Parameters:
- ADDR_W, 8, memory byte-address width
- DATA_W, 32, port word width (fixed at 32; byte lanes = DATA_W/8)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (one clock domain)
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  ADDR_W  fetch byte address (bits [1:0] ignored)
- if_rdata  out  32  fetched instruction, valid from if_done, held until next fetch completes
- if_done  out  1  one-cycle completion pulse
- dm_req  in  1  data request, level, held until dm_done
- dm_rw  in  1  1 = store, 0 = load
- dm_size  in  1  1 = word, 0 = byte
- dm_addr  in  ADDR_W  data byte address (word: bits [1:0] ignored)
- dm_wdata  in  32  store data (byte store uses [7:0])
- dm_rdata  out  32  load data (byte load zero-extended), valid from dm_done, held
- dm_done  out  1  one-cycle completion pulse
- mem_en  out  1  memory byte-cycle enable
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  8  memory write byte
- mem_rdata  in  8  memory read byte, combinational, same cycle as mem_addr
- pc_stall  out  1  = if_req & ~if_done (combinational)
- mem_stall  out  1  = dm_req & ~dm_done (combinational)

## Operation
- FSM states: IDLE, XFER, DONE. The byte counter cnt[1:0] and latched grant, rw, size, base address, and write data are held in registers.
- In IDLE, the FSM samples the requests:
  - Neither request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant DM, unless last_grant = DM, in which case grant IF (anti-starvation).
- On grant, latch the request fields, set cnt = 0, go to XFER.
- In XFER, each cycle is one byte cycle:
  - mem_en = 1.
  - mem_addr = {base[ADDR_W-1:2], cnt} for words, or base for bytes.
  - mem_we = latched rw; IF is always a read.
  - mem_wdata = word byte (3-cnt) for stores, i.e. big-endian: cnt 0 drives [31:24].
  - Reads shift mem_rdata into the assembly register.
  - After the last byte (cnt = 3 for words, immediately for bytes), go to DONE. Otherwise cnt increments.
- In DONE:
  - The granted port's done = 1.
  - The granted port's rdata register updates from the assembly register (DM byte load = {24'b0, byte}).
  - last_grant is updated.
  - mem_en = 0.
  - Next state is IDLE. Requests are not sampled in DONE.
- Requesters drop or replace req on the edge after seeing done.
- Deasserting req mid-transfer does not abort; the transfer completes and done still pulses.
- Fields on the request inputs are ignored after grant.
- Store data is not echoed: dm_rdata is unchanged by stores.
- Misaligned word addresses are force-aligned. Byte addresses never wrap within a transfer.

## Timing
- Reset values of every registered output and internal register:
  - state = IDLE, cnt = 0, last_grant = IF.
  - if_rdata = dm_rdata = 0, if_done = dm_done = 0.
  - mem_en = mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Stall outputs track req during reset.
- Word access, with the request sampled in IDLE at cycle 0:
  - Byte cycles at cycles 1–4.
  - done at cycle 5.
  - Earliest next grant at cycle 6, so a new transfer starts every 6 cycles.
- Byte access: request at cycle 0, byte cycle at 1, done at 2, next grant at 3.
- The memory outputs (mem_en, mem_we, mem_addr, mem_wdata) are registered/decoded from state only. Stores take effect at the end of each byte cycle.
- Reset asserted mid-transfer:
  - mem_en and mem_we drop immediately (asynchronously).
  - The FSM returns to IDLE and no done pulse is issued.
  - Bytes already written stay in memory.
- A request arriving during XFER or DONE waits; it is granted in the first IDLE cycle.

## Structure
- Shared package (mem_arb_pkg):
  - state encodings IDLE/XFER/DONE
  - GRANT_IF/GRANT_DM
  - RW_STORE = 1, SIZE_WORD = 1
  - the LANES constant
- One sub-module, byte_seq:
  - contains the cnt counter, big-endian lane select for writes, shift-in assembly for reads, and a last-byte flag
  - instantiated once
- The top holds the FSM, arbitration and port registers.

## Test plan
- Fetch, no contention: memory [0x10..0x13] = E3 A0 10 05, if_req at cycle 0 with if_addr = 0x12 → byte cycles at addresses 0x10..0x13 in cycles 1–4; if_done in cycle 5 with if_rdata = 0xE3A01005; pc_stall high in cycles 0–4.
- Word store then load: store 0xDEADBEEF to 0x20 → mem_we in 4 cycles writing DE, AD, BE, EF to 0x20..0x23; a load of 0x20 then returns dm_rdata = 0xDEADBEEF.
- Byte load and store:
  - Load from 0x22 returns 0x000000BE after 1 byte cycle, dm_done in cycle 2.
  - Byte store of dm_wdata = 0x12345677 to 0x21 changes only 0x21, to 0x77.
- Simultaneous requests: both asserted at cycle 0 → DM is served first (done at cycle 5), IF at cycle 6 (done at cycle 11). With DM re-requested continuously, the grants alternate IF/DM.
- Reset mid-transfer: reset asserted during a word store at cycle 2 → mem_en = 0 immediately; no dm_done; only bytes 0–1 are written; after release, a fresh request completes normally.
